// File: rtl/spell_pkg.sv
// Shared types and constants for the SPELL memory arbiter.
// Requester IDs double as the owner tag carried through the latency tracker.
package spell_pkg;

    localparam int unsigned LATENCY_MAX = 3;
    localparam int unsigned CNT_W       = 2;
    localparam int unsigned ID_W        = 2;

    typedef enum logic [ID_W-1:0] {
        REQ_NONE  = 2'd0,
        REQ_FETCH = 2'd1,
        REQ_DATA  = 2'd2,
        REQ_DBG   = 2'd3
    } req_id_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Bit 0 fetch, bit 1 data, bit 2 debug; REQ_NONE maps to all zeros.
    function automatic logic [2:0] req_onehot(input req_id_t id);
        logic [2:0] v;
        v    = 3'b000;
        v[0] = (id == REQ_FETCH);
        v[1] = (id == REQ_DATA);
        v[2] = (id == REQ_DBG);
        return v;
    endfunction

endpackage

// File: rtl/spell_mem_arbiter_if.sv
// Requester and memory-side signal bundle of the SPELL memory arbiter.
// slave is the arbiter view; master is the surrounding core/memory view.
interface spell_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              fetch_req;
    logic              data_req;
    logic              dbg_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] data_addr;
    logic [ADDR_W-1:0] dbg_addr;
    logic              data_we;
    logic              dbg_we;
    logic [DATA_W-1:0] data_wdata;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_lock;

    logic              fetch_gnt;
    logic              data_gnt;
    logic              dbg_gnt;
    logic              fetch_done;
    logic              data_done;
    logic              dbg_done;
    logic [DATA_W-1:0] rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  fetch_req, data_req, dbg_req,
        input  fetch_addr, data_addr, dbg_addr,
        input  data_we, dbg_we, data_wdata, dbg_wdata, dbg_lock,
        output fetch_gnt, data_gnt, dbg_gnt,
        output fetch_done, data_done, dbg_done, rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output fetch_req, data_req, dbg_req,
        output fetch_addr, data_addr, dbg_addr,
        output data_we, dbg_we, data_wdata, dbg_wdata, dbg_lock,
        input  fetch_gnt, data_gnt, dbg_gnt,
        input  fetch_done, data_done, dbg_done, rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/spell_arb_tracker.sv
// Tracks the single in-flight access: latency countdown, owner tag and done pulses.
// slot_open marks cycles where a new grant may be issued (idle or final busy cycle).
module spell_arb_tracker import spell_pkg::*; #(
    parameter int unsigned LATENCY = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  req_id_t gnt_id,
    output logic    slot_open,
    output logic    fetch_done,
    output logic    data_done,
    output logic    dbg_done
);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    req_id_t          owner_q, owner_d;
    logic [2:0]       done_q, done_d;

    // Next state; a grant in the final busy cycle re-arms the counter for the new owner.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        done_d  = 3'b000;

        if (state_q == BUSY) begin
            if (cnt_q == CNT_W'(0)) begin
                state_d = IDLE;
                owner_d = REQ_NONE;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        if (gnt_id != REQ_NONE) begin
            state_d = BUSY;
            cnt_d   = CNT_W'(LATENCY - 1);
            owner_d = gnt_id;
        end

        if ((state_d == BUSY) && (cnt_d == CNT_W'(0))) begin
            done_d = req_onehot(owner_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= CNT_W'(0);
            owner_q <= REQ_NONE;
            done_q  <= 3'b000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            done_q  <= done_d;
        end
    end

    assign slot_open  = (state_q == IDLE) || (cnt_q == CNT_W'(0));
    assign fetch_done = done_q[0];
    assign data_done  = done_q[1];
    assign dbg_done   = done_q[2];

endmodule

// File: rtl/spell_mem_arbiter.sv
// Single-port memory arbiter for the SPELL core: debug > round-robin(fetch, data).
// Grants are combinational in a slot; completion timing lives in spell_arb_tracker.
module spell_mem_arbiter import spell_pkg::*; #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned LATENCY = 1
) (
    input logic clk,
    input logic rst,
    spell_mem_arbiter_if.slave bus
);

    req_id_t           win_id;
    logic              slot_open;
    logic              rr_q, rr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_c;
    logic              fetch_done;
    logic              data_done;
    logic              dbg_done;

    // Winner select; nothing is granted while reset is asserted.
    always_comb begin
        win_id = REQ_NONE;
        if (slot_open && !rst) begin
            if (bus.dbg_req) begin
                win_id = REQ_DBG;
            end else if (!bus.dbg_lock) begin
                if (bus.fetch_req && bus.data_req) begin
                    win_id = rr_q ? REQ_DATA : REQ_FETCH;
                end else if (bus.fetch_req) begin
                    win_id = REQ_FETCH;
                end else if (bus.data_req) begin
                    win_id = REQ_DATA;
                end
            end
        end
    end

    // Memory mux and rr update; address/wdata hold their registered copies otherwise.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_c    = 1'b0;
        rr_d    = rr_q;
        case (win_id)
            REQ_FETCH: begin
                addr_d = bus.fetch_addr;
                rr_d   = 1'b1;
            end
            REQ_DATA: begin
                addr_d  = bus.data_addr;
                wdata_d = bus.data_wdata;
                we_c    = bus.data_we;
                rr_d    = 1'b0;
            end
            REQ_DBG: begin
                addr_d  = bus.dbg_addr;
                wdata_d = bus.dbg_wdata;
                we_c    = bus.dbg_we;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q    <= 1'b0;
            addr_q  <= ADDR_W'(0);
            wdata_q <= DATA_W'(0);
        end else begin
            rr_q    <= rr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    spell_arb_tracker #(
        .LATENCY (LATENCY)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .gnt_id     (win_id),
        .slot_open  (slot_open),
        .fetch_done (fetch_done),
        .data_done  (data_done),
        .dbg_done   (dbg_done)
    );

    assign bus.fetch_gnt  = (win_id == REQ_FETCH);
    assign bus.data_gnt   = (win_id == REQ_DATA);
    assign bus.dbg_gnt    = (win_id == REQ_DBG);
    assign bus.mem_en     = (win_id != REQ_NONE);
    assign bus.mem_we     = we_c;
    assign bus.mem_addr   = addr_d;
    assign bus.mem_wdata  = wdata_d;
    assign bus.fetch_done = fetch_done;
    assign bus.data_done  = data_done;
    assign bus.dbg_done   = dbg_done;
    assign bus.rdata      = (fetch_done || data_done || dbg_done) ? bus.mem_rdata : DATA_W'(0);

endmodule
